// File: rtl/target_port_burst.sv
// Target-side serial bus port with parametrised widths and multi-beat bursts.
// Deserialises header and write beats, issues auto-incrementing target accesses, serialises read data.
module target_port_burst #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 8,
    parameter int LEN_BITS   = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  decoder_valid,
    input  logic                  bus_rw,
    input  logic                  bus_data_in,
    input  logic                  bus_data_in_valid,
    input  logic                  bus_mode,
    output logic                  bus_data_out,
    output logic                  bus_data_out_valid,
    output logic                  bus_target_ready,
    output logic                  bus_target_ack,
    output logic                  bus_target_rw,
    output logic                  burst_done,
    output logic                  overrun_err,
    output logic [ADDR_WIDTH-1:0] target_addr_in,
    output logic                  target_addr_in_valid,
    output logic [DATA_WIDTH-1:0] target_data_in,
    output logic                  target_data_in_valid,
    output logic                  target_rw,
    input  logic [DATA_WIDTH-1:0] target_data_out,
    input  logic                  target_data_out_valid,
    input  logic                  target_ack,
    input  logic                  target_ready
);

    localparam int HDR_BITS = ADDR_WIDTH + LEN_BITS;
    localparam int HCW      = $clog2(HDR_BITS + 1);
    localparam int DCW      = $clog2(DATA_WIDTH + 1);

    typedef enum logic [2:0] {
        IDLE,
        HDR,
        WDATA,
        WREQ,
        RREQ,
        RSHIFT,
        DONE
    } state_t;

    state_t                 state;
    logic [HDR_BITS-2:0]    hdr_sr;
    logic [HCW-1:0]         hdr_cnt;
    logic [DATA_WIDTH-2:0]  din_sr;
    logic [DCW-1:0]         din_cnt;
    logic [DATA_WIDTH-1:0]  skid;
    logic                   skid_full;
    logic [LEN_BITS-1:0]    beats_left;
    logic [DATA_WIDTH-2:0]  rd_sr;
    logic [DCW-1:0]         rd_cnt;

    logic                   hdr_bit;
    logic                   dat_bit;
    logic                   hdr_last;
    logic                   din_last;
    logic                   word_done;
    logic [HDR_BITS-1:0]    hdr_next;
    logic [DATA_WIDTH-1:0]  din_next;

    assign bus_target_ready = target_ready;
    assign bus_target_ack   = target_ack;
    assign bus_target_rw    = target_rw;

    // Shift registers hold only the bits already received; the live bit completes the word.
    assign hdr_bit   = decoder_valid && bus_data_in_valid && !bus_mode;
    assign dat_bit   = decoder_valid && bus_data_in_valid && bus_mode;
    assign hdr_next  = {bus_data_in, hdr_sr};
    assign din_next  = {bus_data_in, din_sr};
    assign hdr_last  = (hdr_cnt == HCW'(HDR_BITS - 1));
    assign din_last  = (din_cnt == DCW'(DATA_WIDTH - 1));
    assign word_done = dat_bit && din_last;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state                <= IDLE;
            hdr_sr               <= '0;
            hdr_cnt              <= '0;
            din_sr               <= '0;
            din_cnt              <= '0;
            skid                 <= '0;
            skid_full            <= 1'b0;
            beats_left           <= '0;
            rd_sr                <= '0;
            rd_cnt               <= '0;
            bus_data_out         <= 1'b0;
            bus_data_out_valid   <= 1'b0;
            burst_done           <= 1'b0;
            overrun_err          <= 1'b0;
            target_addr_in       <= '0;
            target_addr_in_valid <= 1'b0;
            target_data_in       <= '0;
            target_data_in_valid <= 1'b0;
            target_rw            <= 1'b0;
        end else if (state != IDLE && !decoder_valid) begin
            state                <= IDLE;
            hdr_cnt              <= '0;
            din_cnt              <= '0;
            skid_full            <= 1'b0;
            bus_data_out         <= 1'b0;
            bus_data_out_valid   <= 1'b0;
            burst_done           <= 1'b0;
            target_addr_in_valid <= 1'b0;
            target_data_in_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hdr_bit) begin
                        state     <= HDR;
                        target_rw <= bus_rw;
                        hdr_sr    <= hdr_next[HDR_BITS-1:1];
                        hdr_cnt   <= HCW'(1);
                        din_cnt   <= '0;
                        skid_full <= 1'b0;
                    end
                end

                HDR: begin
                    if (hdr_bit) begin
                        hdr_sr <= hdr_next[HDR_BITS-1:1];
                        if (hdr_last) begin
                            hdr_cnt        <= '0;
                            target_addr_in <= hdr_next[ADDR_WIDTH-1:0];
                            beats_left     <= hdr_next[HDR_BITS-1 -: LEN_BITS];
                            if (target_rw) begin
                                state <= WDATA;
                            end else begin
                                state                <= RREQ;
                                target_addr_in_valid <= target_ready;
                            end
                        end else begin
                            hdr_cnt <= hdr_cnt + 1'b1;
                        end
                    end
                end

                WDATA: begin
                    if (dat_bit) begin
                        din_sr  <= din_next[DATA_WIDTH-1:1];
                        din_cnt <= din_last ? '0 : din_cnt + 1'b1;
                        if (din_last) begin
                            state                <= WREQ;
                            target_data_in       <= din_next;
                            target_addr_in_valid <= target_ready;
                            target_data_in_valid <= target_ready;
                        end
                    end
                end

                // Incoming beats keep landing in the skid buffer while the current beat waits for ack;
                // a beat that completes on the ack edge goes straight to the request registers.
                WREQ: begin
                    if (dat_bit) begin
                        din_sr  <= din_next[DATA_WIDTH-1:1];
                        din_cnt <= din_last ? '0 : din_cnt + 1'b1;
                    end
                    if (target_addr_in_valid && target_ack) begin
                        target_addr_in_valid <= 1'b0;
                        target_data_in_valid <= 1'b0;
                        if (beats_left == '0) begin
                            state      <= DONE;
                            burst_done <= 1'b1;
                            skid_full  <= 1'b0;
                        end else begin
                            beats_left     <= beats_left - 1'b1;
                            target_addr_in <= target_addr_in + 1'b1;
                            if (skid_full) begin
                                target_data_in       <= skid;
                                target_addr_in_valid <= target_ready;
                                target_data_in_valid <= target_ready;
                                skid_full            <= word_done;
                                if (word_done) begin
                                    skid <= din_next;
                                end
                            end else if (word_done) begin
                                target_data_in       <= din_next;
                                target_addr_in_valid <= target_ready;
                                target_data_in_valid <= target_ready;
                            end else begin
                                state <= WDATA;
                            end
                        end
                    end else begin
                        if (!target_addr_in_valid && target_ready) begin
                            target_addr_in_valid <= 1'b1;
                            target_data_in_valid <= 1'b1;
                        end
                        if (word_done) begin
                            if (skid_full) begin
                                overrun_err <= 1'b1;
                            end else begin
                                skid      <= din_next;
                                skid_full <= 1'b1;
                            end
                        end
                    end
                end

                RREQ: begin
                    if (target_addr_in_valid && target_data_out_valid) begin
                        state                <= RSHIFT;
                        target_addr_in_valid <= 1'b0;
                        rd_sr                <= target_data_out[DATA_WIDTH-1:1];
                        rd_cnt               <= '0;
                        bus_data_out         <= target_data_out[0];
                        bus_data_out_valid   <= 1'b1;
                    end else if (!target_addr_in_valid && target_ready) begin
                        target_addr_in_valid <= 1'b1;
                    end
                end

                RSHIFT: begin
                    if (rd_cnt == DCW'(DATA_WIDTH - 1)) begin
                        bus_data_out       <= 1'b0;
                        bus_data_out_valid <= 1'b0;
                        if (beats_left == '0) begin
                            state      <= DONE;
                            burst_done <= 1'b1;
                        end else begin
                            state                <= RREQ;
                            beats_left           <= beats_left - 1'b1;
                            target_addr_in       <= target_addr_in + 1'b1;
                            target_addr_in_valid <= target_ready;
                        end
                    end else begin
                        bus_data_out <= rd_sr[0];
                        rd_sr        <= rd_sr >> 1;
                        rd_cnt       <= rd_cnt + 1'b1;
                    end
                end

                DONE: begin
                    burst_done <= 1'b0;
                    state      <= IDLE;
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_target_port_burst.sv
// Bench for target_port_burst: transaction-level model of bus writes/reads against a target memory,
// with directed scenarios (wrap, overrun, abort, reset mid-read) and randomized bursts.
module tb_target_port_burst;

    localparam int AW = 16;
    localparam int DW = 8;
    localparam int LB = 2;
    localparam int HB = AW + LB;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          decoder_valid = 1'b0;
    logic          bus_rw = 1'b0;
    logic          bus_data_in = 1'b0;
    logic          bus_data_in_valid = 1'b0;
    logic          bus_mode = 1'b0;
    logic          bus_data_out, bus_data_out_valid;
    logic          bus_target_ready, bus_target_ack, bus_target_rw;
    logic          burst_done, overrun_err;
    logic [AW-1:0] target_addr_in;
    logic          target_addr_in_valid;
    logic [DW-1:0] target_data_in;
    logic          target_data_in_valid;
    logic          target_rw;
    logic [DW-1:0] target_data_out = '0;
    logic          target_data_out_valid = 1'b0;
    logic          target_ack = 1'b0;
    logic          target_ready = 1'b0;

    always #5 clk = ~clk;

    target_port_burst #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LEN_BITS(LB)) dut (
        .clk(clk), .rst_n(rst_n), .decoder_valid(decoder_valid), .bus_rw(bus_rw),
        .bus_data_in(bus_data_in), .bus_data_in_valid(bus_data_in_valid), .bus_mode(bus_mode),
        .bus_data_out(bus_data_out), .bus_data_out_valid(bus_data_out_valid),
        .bus_target_ready(bus_target_ready), .bus_target_ack(bus_target_ack),
        .bus_target_rw(bus_target_rw), .burst_done(burst_done), .overrun_err(overrun_err),
        .target_addr_in(target_addr_in), .target_addr_in_valid(target_addr_in_valid),
        .target_data_in(target_data_in), .target_data_in_valid(target_data_in_valid),
        .target_rw(target_rw), .target_data_out(target_data_out),
        .target_data_out_valid(target_data_out_valid), .target_ack(target_ack),
        .target_ready(target_ready)
    );

    int n_checks = 0;
    int n_fail   = 0;

    function automatic void chk(input string name, input longint act, input longint exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endfunction

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } acc_t;

    logic [DW-1:0] model_mem [int];
    logic [DW-1:0] tgt_mem   [int];
    acc_t          exp_wr[$];
    logic [AW-1:0] exp_rd_addr[$];
    logic [DW-1:0] exp_rd_data[$];
    logic [AW-1:0] cap_wr_addr[$];
    logic [DW-1:0] cap_wr_data[$];
    int            exp_done = 0;
    int            done_cnt = 0;
    int            wr_acc = 0;
    int            cyc = 0;
    int            done_cyc = 0;
    int            acc_cyc = 0;
    int            last_bit_cyc = 0;
    logic [DW-1:0] last_rd_byte = '0;
    int            fixed_delay = -1;
    bit            ready_rand = 1'b0;

    function automatic logic [DW-1:0] dflt(input int a);
        return DW'(a) ^ DW'(a >> 8) ^ 8'h5A;
    endfunction

    function automatic logic [DW-1:0] model_rd(input int a);
        return model_mem.exists(a) ? model_mem[a] : dflt(a);
    endfunction

    // Observer: every cycle, checks pass-throughs and idle output, and scores accepted accesses and read bytes.
    initial begin
        int            rd_bits;
        logic [DW-1:0] rd_byte;
        bit            prev_done;
        acc_t          e;
        rd_bits   = 0;
        rd_byte   = '0;
        prev_done = 1'b0;
        forever begin
            @(negedge clk);
            cyc++;
            chk("pass_ready", bus_target_ready, target_ready);
            chk("pass_ack", bus_target_ack, target_ack);
            chk("pass_rw", bus_target_rw, target_rw);
            if (!rst_n) begin
                rd_bits   = 0;
                prev_done = 1'b0;
            end else begin
                if (!bus_data_out_valid) chk("dout_idle_zero", bus_data_out, 0);
                if (target_data_in_valid) chk("dv_implies_av", target_addr_in_valid, 1);
                if (burst_done) begin
                    chk("done_one_cycle", prev_done, 0);
                    done_cnt++;
                    done_cyc = cyc;
                end
                prev_done = burst_done;
                if (target_addr_in_valid && target_ack && target_rw) begin
                    chk("wr_expected_pending", exp_wr.size() > 0, 1);
                    chk("wr_data_valid", target_data_in_valid, 1);
                    if (exp_wr.size() > 0) begin
                        e = exp_wr.pop_front();
                        chk("wr_addr", target_addr_in, e.a);
                        chk("wr_data", target_data_in, e.d);
                    end
                    tgt_mem[int'(target_addr_in)] = target_data_in;
                    cap_wr_addr.push_back(target_addr_in);
                    cap_wr_data.push_back(target_data_in);
                    wr_acc++;
                    acc_cyc = cyc;
                end
                if (target_addr_in_valid && target_data_out_valid && !target_rw) begin
                    chk("rd_expected_pending", exp_rd_addr.size() > 0, 1);
                    if (exp_rd_addr.size() > 0) chk("rd_addr", target_addr_in, exp_rd_addr.pop_front());
                end
                if (bus_data_out_valid) begin
                    rd_byte[rd_bits] = bus_data_out;
                    rd_bits++;
                    if (rd_bits == DW) begin
                        rd_bits = 0;
                        last_rd_byte = rd_byte;
                        last_bit_cyc = cyc;
                        chk("rd_byte_pending", exp_rd_data.size() > 0, 1);
                        if (exp_rd_data.size() > 0) chk("rd_byte", rd_byte, exp_rd_data.pop_front());
                    end
                end
            end
        end
    end

    // Target model: responds after a delay; reads may see stray acks that must not complete them.
    initial begin
        bit busy;
        int wcnt;
        busy = 1'b0;
        wcnt = 0;
        forever begin
            @(posedge clk);
            #1;
            target_ack            = 1'b0;
            target_data_out_valid = 1'b0;
            target_data_out       = DW'($urandom);
            target_ready          = ready_rand ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (!target_addr_in_valid || !rst_n) begin
                busy = 1'b0;
            end else begin
                if (!busy) begin
                    busy = 1'b1;
                    wcnt = (fixed_delay >= 0) ? fixed_delay : int'($urandom_range(0, 3));
                end
                if (wcnt == 0) begin
                    busy = 1'b0;
                    if (target_rw) begin
                        target_ack = 1'b1;
                    end else begin
                        target_data_out = tgt_mem.exists(int'(target_addr_in)) ?
                                          tgt_mem[int'(target_addr_in)] : dflt(int'(target_addr_in));
                        target_data_out_valid = 1'b1;
                        target_ack = 1'($urandom_range(0, 1));
                    end
                end else begin
                    wcnt--;
                    if (!target_rw && $urandom_range(0, 2) == 0) target_ack = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_bit(input logic v, input logic b, input logic m, input logic rw);
        decoder_valid     = 1'b1;
        bus_data_in_valid = v;
        bus_data_in       = v ? b : 1'($urandom);
        bus_mode          = m;
        bus_rw            = rw;
        tick();
        bus_data_in_valid = 1'b0;
    endtask

    task automatic send_hdr(input logic rw, input logic [AW-1:0] a, input int len, input bit noisy);
        logic [HB-1:0] h;
        h = {LB'(len), a};
        for (int i = 0; i < HB; i++) begin
            if (noisy && i > 0) begin
                repeat ($urandom_range(0, 1)) drive_bit(1'($urandom), 1'($urandom), 1'b1, 1'($urandom));
            end
            drive_bit(1'b1, h[i], 1'b0, (i == 0) ? rw : 1'($urandom));
        end
    endtask

    task automatic send_beat(input logic [DW-1:0] d, input bit gaps);
        for (int i = 0; i < DW; i++) begin
            if (gaps) repeat ($urandom_range(0, 1)) drive_bit(1'b0, 1'b0, 1'b1, 1'($urandom));
            drive_bit(1'b1, d[i], 1'b1, 1'($urandom));
        end
    endtask

    task automatic end_txn();
        int n;
        n = 0;
        while (done_cnt < exp_done && n < 1000) begin
            tick();
            n++;
        end
        chk("burst_done_count", done_cnt, exp_done);
        decoder_valid = 1'b0;
        tick();
    endtask

    task automatic wait_accepts(input int target, input int base);
        int n;
        n = 0;
        while (wr_acc - base < target && n < 300) begin
            tick();
            n++;
        end
        chk("accept_wait", wr_acc - base >= target, 1);
    endtask

    task automatic wr_txn(input logic [AW-1:0] base, input int len, input logic [DW-1:0] d0,
                          input logic [DW-1:0] d1, input logic [DW-1:0] d2, input logic [DW-1:0] d3,
                          input bit noisy);
        logic [DW-1:0] d[4];
        logic [AW-1:0] a;
        int            b0;
        d = '{d0, d1, d2, d3};
        for (int i = 0; i <= len; i++) begin
            a = base + AW'(i);
            exp_wr.push_back('{a: a, d: d[i]});
            model_mem[int'(a)] = d[i];
        end
        exp_done++;
        b0 = wr_acc;
        send_hdr(1'b1, base, len, noisy);
        for (int j = 0; j <= len; j++) begin
            if (j >= 2) wait_accepts(j - 1, b0);
            send_beat(d[j], noisy);
        end
        end_txn();
    endtask

    task automatic rd_txn(input logic [AW-1:0] base, input int len, input bit noisy);
        logic [AW-1:0] a;
        for (int i = 0; i <= len; i++) begin
            a = base + AW'(i);
            exp_rd_addr.push_back(a);
            exp_rd_data.push_back(model_rd(int'(a)));
        end
        exp_done++;
        send_hdr(1'b0, base, len, noisy);
        end_txn();
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int            b0;
        int            n;
        logic [AW-1:0] wrap_a[4];
        logic [DW-1:0] wrap_d[4];
        logic [HB-1:0] h;

        // Reset state
        repeat (3) tick();
        chk("rst_dout_valid", bus_data_out_valid, 0);
        chk("rst_dout", bus_data_out, 0);
        chk("rst_addr_valid", target_addr_in_valid, 0);
        chk("rst_data_valid", target_data_in_valid, 0);
        chk("rst_done", burst_done, 0);
        chk("rst_overrun", overrun_err, 0);
        chk("rst_rw", target_rw, 0);
        chk("rst_addr", target_addr_in, 0);
        chk("rst_data", target_data_in, 0);
        rst_n = 1'b1;
        tick();

        // Single write 0x0532 <- 0x9E
        cap_wr_addr.delete();
        cap_wr_data.delete();
        wr_txn(16'h0532, 0, 8'h9E, 8'h00, 8'h00, 8'h00, 1'b0);
        chk("single_wr_count", cap_wr_addr.size(), 1);
        if (cap_wr_addr.size() > 0) begin
            chk("single_wr_addr_lit", cap_wr_addr[0], 16'h0532);
            chk("single_wr_data_lit", cap_wr_data[0], 8'h9E);
        end
        chk("done_after_ack", done_cyc - acc_cyc, 1);

        // Read back 0x0532
        rd_txn(16'h0532, 0, 1'b0);
        chk("readback_lit", last_rd_byte, 8'h9E);
        chk("done_after_8th_bit", done_cyc - last_bit_cyc, 1);

        // Wrapping write burst
        cap_wr_addr.delete();
        cap_wr_data.delete();
        wr_txn(16'hFFFE, 3, 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);
        wrap_a = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
        wrap_d = '{8'h11, 8'h22, 8'h33, 8'h44};
        chk("wrap_count", cap_wr_addr.size(), 4);
        for (int i = 0; i < 4; i++) begin
            if (i < cap_wr_addr.size()) begin
                chk("wrap_addr_lit", cap_wr_addr[i], wrap_a[i]);
                chk("wrap_data_lit", cap_wr_data[i], wrap_d[i]);
            end
        end
        chk("wrap_no_overrun", overrun_err, 0);
        rd_txn(16'hFFFF, 1, 1'b0);
        chk("wrap_readback_lit", last_rd_byte, 8'h33);

        // Overrun: slow ack, beats streamed back-to-back; third beat dropped
        fixed_delay = 20;
        cap_wr_addr.delete();
        cap_wr_data.delete();
        exp_wr.push_back('{a: 16'h4000, d: 8'hA1});
        exp_wr.push_back('{a: 16'h4001, d: 8'hB2});
        exp_wr.push_back('{a: 16'h4002, d: 8'hD4});
        model_mem[16'h4000] = 8'hA1;
        model_mem[16'h4001] = 8'hB2;
        model_mem[16'h4002] = 8'hD4;
        exp_done++;
        b0 = wr_acc;
        send_hdr(1'b1, 16'h4000, 2, 1'b0);
        send_beat(8'hA1, 1'b0);
        send_beat(8'hB2, 1'b0);
        chk("overrun_before_3rd", overrun_err, 0);
        send_beat(8'hC3, 1'b0);
        chk("overrun_on_3rd", overrun_err, 1);
        wait_accepts(2, b0);
        send_beat(8'hD4, 1'b0);
        end_txn();
        fixed_delay = -1;
        chk("overrun_sticky", overrun_err, 1);
        chk("overrun_issue_count", cap_wr_data.size(), 3);
        for (int i = 0; i < cap_wr_data.size(); i++) chk("overrun_dropped_beat", cap_wr_data[i] == 8'hC3, 0);

        // decoder_valid dropped mid-header
        h = {2'd0, 16'h2222};
        for (int i = 0; i < 9; i++) drive_bit(1'b1, h[i], 1'b0, (i == 0) ? 1'b1 : 1'b0);
        decoder_valid = 1'b0;
        for (int i = 0; i < 6; i++) begin
            tick();
            chk("abort_no_addr_valid", target_addr_in_valid, 0);
            chk("abort_no_data_valid", target_data_in_valid, 0);
        end
        wr_txn(16'h00A0, 0, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0);
        rd_txn(16'h00A0, 0, 1'b0);
        chk("after_abort_lit", last_rd_byte, 8'h3C);

        // Reset for one cycle during RSHIFT
        exp_rd_addr.push_back(16'h0532);
        exp_rd_data.push_back(model_rd(16'h0532));
        send_hdr(1'b0, 16'h0532, 0, 1'b0);
        n = 0;
        while (!bus_data_out_valid && n < 100) begin
            tick();
            n++;
        end
        chk("rshift_reached", bus_data_out_valid, 1);
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        decoder_valid = 1'b0;
        chk("mid_rst_dout_valid", bus_data_out_valid, 0);
        chk("mid_rst_dout", bus_data_out, 0);
        chk("mid_rst_addr_valid", target_addr_in_valid, 0);
        chk("mid_rst_data_valid", target_data_in_valid, 0);
        chk("mid_rst_overrun", overrun_err, 0);
        chk("mid_rst_rw", target_rw, 0);
        chk("mid_rst_addr", target_addr_in, 0);
        if (exp_rd_data.size() > 0) void'(exp_rd_data.pop_front());
        repeat (12) begin
            tick();
            chk("mid_rst_quiet", bus_data_out_valid, 0);
        end
        chk("mid_rst_no_done", done_cnt, exp_done);

        // Randomized bursts with gaps, header noise and random target readiness
        ready_rand = 1'b1;
        for (int t = 0; t < 30; t++) begin
            logic [AW-1:0] a;
            int            len;
            a   = ($urandom_range(0, 3) == 0) ? 16'hFFFC + AW'($urandom_range(0, 3))
                                               : 16'h1000 + AW'($urandom_range(0, 15));
            len = int'($urandom_range(0, 3));
            if ($urandom_range(0, 1) == 0)
                wr_txn(a, len, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom), 1'b1);
            else
                rd_txn(a, len, 1'b1);
        end
        chk("random_no_overrun", overrun_err, 0);
        chk("exp_wr_drained", exp_wr.size(), 0);
        chk("exp_rd_addr_drained", exp_rd_addr.size(), 0);
        chk("exp_rd_data_drained", exp_rd_data.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
